// File: rtl/mem_access_unit_pkg.sv
// Shared constants for the M-stage data-memory access unit: access-size
// codes, response error codes, FSM states and a size helper.
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    DMOp_b = 2'd0,
    DMOp_h = 2'd1,
    DMOp_w = 2'd2,
    DMOp_d = 2'd3
  } dm_op_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_ALIGN   = 2'd1,
    ERR_TIMEOUT = 2'd2
  } err_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Low-address bits that must be zero for an access of this size.
  function automatic logic [3:0] op_align_mask(dm_op_e op);
    case (op)
      DMOp_b:  return 4'b0000;
      DMOp_h:  return 4'b0001;
      DMOp_w:  return 4'b0011;
      default: return 4'b0111;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request, bus and response signals of the access unit. The master side is
// the access unit itself; the slave side is the pipeline plus data memory.
interface mem_access_unit_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  localparam int NB = DATA_W / 8;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_op;
  logic              req_sext;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [NB-1:0]     mem_be;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  logic              rsp_valid;
  logic [1:0]        rsp_err;
  logic [DATA_W-1:0] rsp_rdata;
  logic              busy;

  modport master (
    input  req_valid, req_we, req_op, req_sext, req_addr, req_wdata,
    input  mem_ack, mem_rdata,
    output req_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output rsp_valid, rsp_err, rsp_rdata, busy
  );

  modport slave (
    output req_valid, req_we, req_op, req_sext, req_addr, req_wdata,
    output mem_ack, mem_rdata,
    input  req_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  rsp_valid, rsp_err, rsp_rdata, busy
  );
endinterface

// File: rtl/mem_access_unit_lane.sv
// Combinational lane logic: store byte enables and lane shift, alignment
// check, and load extraction with sign/zero extension.
module mem_lane_ext
  import mem_access_unit_pkg::*;
#(
  parameter  int DATA_W = 32,
  localparam int NB     = DATA_W / 8,
  localparam int LW     = $clog2(NB)
) (
  input  dm_op_e            st_op,
  input  logic              st_we,
  input  logic [LW-1:0]     st_lane,
  input  logic [DATA_W-1:0] st_wdata,
  output logic [NB-1:0]     st_be,
  output logic [DATA_W-1:0] st_wdata_lane,
  output logic              st_misaligned,

  input  dm_op_e            ld_op,
  input  logic              ld_sext,
  input  logic [LW-1:0]     ld_lane,
  input  logic [DATA_W-1:0] ld_rdata,
  output logic [DATA_W-1:0] ld_data
);

  // Bits of a right-aligned value that belong to an access of this size.
  function automatic logic [DATA_W-1:0] width_mask(dm_op_e op);
    case (op)
      DMOp_b:  return DATA_W'(8'hFF);
      DMOp_h:  return DATA_W'(16'hFFFF);
      DMOp_w:  return DATA_W'(32'hFFFF_FFFF);
      default: return '1;
    endcase
  endfunction

  logic [DATA_W-1:0] ld_shift;
  logic [DATA_W-1:0] ld_keep;
  logic              ld_msb;

  // Store side: byte enables and data moved to the addressed lane; zero on reads.
  always_comb begin
    // NOTE: outputs get a default before any branch so no path infers a latch.
    st_be         = '0;
    st_wdata_lane = '0;
    if (st_we) begin
      case (st_op)
        DMOp_b:  st_be = NB'(1'b1)  << st_lane;
        DMOp_h:  st_be = NB'(2'b11) << st_lane;
        DMOp_w:  st_be = NB'(4'hF)  << st_lane;
        default: st_be = '1;
      endcase
      st_wdata_lane = (st_wdata & width_mask(st_op)) << {st_lane, 3'b000};
    end
  end

  // A double on a 32-bit bus is illegal regardless of address.
  assign st_misaligned = ((st_lane & LW'(op_align_mask(st_op))) != '0) ||
                         (st_op == DMOp_d && DATA_W < 64);

  // Load side: pull the lane down to bit 0, then extend from the access MSB.
  always_comb begin
    ld_shift = ld_rdata >> {ld_lane, 3'b000};
    ld_keep  = width_mask(ld_op);
    case (ld_op)
      DMOp_b:  ld_msb = ld_shift[7];
      DMOp_h:  ld_msb = ld_shift[15];
      DMOp_w:  ld_msb = ld_shift[31];
      default: ld_msb = 1'b0;
    endcase
    ld_data = (ld_shift & ld_keep) | ((ld_sext && ld_msb) ? ~ld_keep : '0);
  end

endmodule

// File: rtl/mem_access_unit.sv
// M-stage data-memory access unit: accepts one load/store, issues an aligned
// byte-enabled bus request, waits (with optional timeout) for the ack and
// returns a one-cycle response. All outputs are registered.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input logic               clk,
  input logic               reset,
  mem_access_unit_if.master bus
);

  localparam int NB    = DATA_W / 8;
  localparam int LW    = $clog2(NB);
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_e            state;
  dm_op_e            op_q;
  logic              sext_q;
  logic              we_q;
  logic [LW-1:0]     lane_q;
  logic [CNT_W-1:0]  wait_cnt;

  logic [NB-1:0]     st_be;
  logic [DATA_W-1:0] st_wdata;
  logic              st_misaligned;
  logic [DATA_W-1:0] ld_data;

  // Store side sees the live request (it is registered on accept); load side
  // sees the registered request and the live bus read data.
  mem_lane_ext #(.DATA_W(DATA_W)) u_lane (
    .st_op         (dm_op_e'(bus.req_op)),
    .st_we         (bus.req_we),
    .st_lane       (bus.req_addr[LW-1:0]),
    .st_wdata      (bus.req_wdata),
    .st_be         (st_be),
    .st_wdata_lane (st_wdata),
    .st_misaligned (st_misaligned),
    .ld_op         (op_q),
    .ld_sext       (sext_q),
    .ld_lane       (lane_q),
    .ld_rdata      (bus.mem_rdata),
    .ld_data       (ld_data)
  );

  // FSM with request registers, wait counter and every registered output.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      op_q          <= DMOp_b;
      sext_q        <= 1'b0;
      we_q          <= 1'b0;
      lane_q        <= '0;
      wait_cnt      <= '0;
      bus.req_ready <= 1'b1;
      bus.busy      <= 1'b0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_be    <= '0;
      bus.mem_wdata <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_err   <= ERR_NONE;
      bus.rsp_rdata <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      case (state)
        ST_IDLE: begin
          if (bus.req_valid && bus.req_ready) begin
            op_q          <= dm_op_e'(bus.req_op);
            sext_q        <= bus.req_sext;
            we_q          <= bus.req_we;
            lane_q        <= bus.req_addr[LW-1:0];
            wait_cnt      <= '0;
            bus.req_ready <= 1'b0;
            bus.busy      <= 1'b1;
            if (st_misaligned) begin
              state         <= ST_RESP;
              bus.rsp_valid <= 1'b1;
              bus.rsp_err   <= ERR_ALIGN;
              bus.rsp_rdata <= '0;
            end else begin
              state         <= ST_BUS;
              bus.mem_req   <= 1'b1;
              bus.mem_we    <= bus.req_we;
              bus.mem_addr  <= {bus.req_addr[ADDR_W-1:LW], LW'(0)};
              bus.mem_be    <= st_be;
              bus.mem_wdata <= st_wdata;
            end
          end
        end
        ST_BUS: begin
          if (bus.mem_ack) begin
            state         <= ST_RESP;
            bus.mem_req   <= 1'b0;
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= ERR_NONE;
            bus.rsp_rdata <= we_q ? '0 : ld_data;
          end else if (TIMEOUT != 0 && wait_cnt == CNT_LAST) begin
            state         <= ST_RESP;
            bus.mem_req   <= 1'b0;
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= ERR_TIMEOUT;
            bus.rsp_rdata <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_RESP: begin
          state         <= ST_IDLE;
          bus.rsp_valid <= 1'b0;
          bus.rsp_err   <= ERR_NONE;
          bus.rsp_rdata <= '0;
          bus.req_ready <= 1'b1;
          bus.busy      <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
